// File: rtl/sched_pkg.sv
// Shared types and timer register map for the sample interval scheduler.
package sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtrl,
    StArmed,
    StClrStat,
    StReq,
    StStopping
  } sched_state_e;

  // Interval timer register indices.
  localparam logic [2:0] TMR_REG_STATUS   = 3'd0;
  localparam logic [2:0] TMR_REG_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_REG_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_REG_PERIOD_H = 3'd3;

  // Control register bit positions.
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  // Continuous run with timeout interrupt enabled.
  localparam logic [15:0] CTRL_RUN_WORD =
      16'((1 << CTRL_START) | (1 << CTRL_CONT) | (1 << CTRL_ITO));
  // Stop, with every other control bit (including ITO) cleared.
  localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);

endpackage

// File: rtl/sched_ack_watchdog.sv
// Counts cycles a sample request has been outstanding and flags the final one.
module sched_ack_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Cycle counter: zero while idle, advances each cycle a request is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The ACK_TIMEOUT-th cycle of a held request is the last one allowed.
  assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/sample_interval_scheduler.sv
// Programs the interval timer, services its timeout IRQ and hands each tick to the
// temperature sample reader as one req/ack handshake.
module sample_interval_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_enable,
  input  logic             cfg_update,
  input  logic [31:0]      cfg_period,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic             tmr_irq,
  output logic             sample_req,
  input  logic             sample_ack,
  output logic             busy,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] missed_count,
  output logic             ack_timeout
);

  sched_state_e state_q, state_d;
  logic [31:0]      period_q;
  logic             enable_q;
  logic             irq_q;
  logic [CNT_W-1:0] sample_count_q;
  logic [CNT_W-1:0] missed_count_q;
  logic             ack_timeout_q;

  logic        load_period;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        in_req;
  logic        expire;
  logic        enable_rise;
  logic        irq_rise;
  logic        ack_done;
  logic        timed_out;
  logic        update_ok;

  assign in_req      = (state_q == StReq);
  assign enable_rise = cfg_enable && !enable_q;
  assign irq_rise    = tmr_irq && !irq_q;
  assign ack_done    = in_req && sample_ack;
  // A coincident ack beats the timeout.
  assign timed_out   = expire && !sample_ack;
  assign update_ok   = (state_q == StArmed) || (state_q == StClrStat) || (state_q == StReq);

  sched_ack_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!in_req),
    .run     (in_req),
    .expire  (expire)
  );

  // Next state and the single bus write each state issues.
  always_comb begin
    state_d     = state_q;
    load_period = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = 3'd0;
    wr_data     = 16'd0;
    unique case (state_q)
      StIdle: begin
        if (enable_rise) begin
          state_d     = StWrPl;
          load_period = 1'b1;
        end
      end
      StWrPl: begin
        wr_en   = 1'b1;
        wr_addr = TMR_REG_PERIOD_L;
        wr_data = period_q[15:0];
        state_d = StWrPh;
      end
      StWrPh: begin
        wr_en   = 1'b1;
        wr_addr = TMR_REG_PERIOD_H;
        wr_data = period_q[31:16];
        state_d = StWrCtrl;
      end
      StWrCtrl: begin
        wr_en   = 1'b1;
        wr_addr = TMR_REG_CONTROL;
        wr_data = CTRL_RUN_WORD;
        state_d = StArmed;
      end
      StArmed: begin
        if (tmr_irq) begin
          state_d = StClrStat;
        end
      end
      StClrStat: begin
        wr_en   = 1'b1;
        wr_addr = TMR_REG_STATUS;
        wr_data = 16'd0;
        state_d = StReq;
      end
      StReq: begin
        if (sample_ack || expire) begin
          state_d = StArmed;
        end
      end
      StStopping: begin
        wr_en   = 1'b1;
        wr_addr = TMR_REG_CONTROL;
        wr_data = CTRL_STOP_WORD;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Disable overrides update, which overrides IRQ servicing; the write issued this
    // cycle always completes because bus outputs depend only on the current state.
    if ((state_q != StIdle) && (state_q != StStopping)) begin
      if (!cfg_enable) begin
        state_d = StStopping;
      end else if (cfg_update && update_ok) begin
        state_d     = StWrPl;
        load_period = 1'b1;
      end
    end
  end

  // State register, edge-detect history and captured period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      enable_q <= 1'b0;
      irq_q    <= 1'b0;
      period_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      enable_q <= cfg_enable;
      irq_q    <= tmr_irq;
      if (load_period) begin
        period_q <= cfg_period;
      end
    end
  end

  // Completed-sample (wrapping) and overrun (saturating) counters, sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_count_q <= '0;
      missed_count_q <= '0;
      ack_timeout_q  <= 1'b0;
    end else begin
      if (ack_done) begin
        sample_count_q <= sample_count_q + CNT_W'(1);
      end
      if (in_req && irq_rise && !(&missed_count_q)) begin
        missed_count_q <= missed_count_q + CNT_W'(1);
      end
      if (in_req && timed_out) begin
        ack_timeout_q <= 1'b1;
      end else if (enable_rise) begin
        ack_timeout_q <= 1'b0;
      end
    end
  end

  assign tmr_chipselect = wr_en;
  assign tmr_write_n    = !wr_en;
  assign tmr_address    = wr_addr;
  assign tmr_writedata  = wr_data;
  assign sample_req     = in_req;
  assign busy           = (state_q != StIdle);
  assign sample_count   = sample_count_q;
  assign missed_count   = missed_count_q;
  assign ack_timeout    = ack_timeout_q;

endmodule
